// File: rtl/bcd_scan_driver_pkg.sv
// Shared display types and constants for the multiplexed 4-digit BCD counter/driver.
package bcd_scan_driver_pkg;
    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [NUM_DIGITS-1:0] bcd_word_t;
    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
        return {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    endfunction
endpackage

// File: rtl/bcd_scan_driver_if.sv
// Counter controls in, decoder/cathode drive out.
interface bcd_scan_driver_if;
    import bcd_scan_driver_pkg::*;

    logic                  inc;
    logic                  clr;
    logic                  hold;
    logic                  lamp_test;
    bcd_digit_t            bcd;
    logic                  bi_n;
    logic                  lt_n;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  ovf;

    modport master (output inc, clr, hold, lamp_test,
                    input  bcd, bi_n, lt_n, digit_sel, ovf);
    modport slave  (input  inc, clr, hold, lamp_test,
                    output bcd, bi_n, lt_n, digit_sel, ovf);
endinterface

// File: rtl/bcd_decade.sv
// One BCD decade 0..9; carry_out is combinational so a carry ripples through all decades in one cycle.
module bcd_decade
    import bcd_scan_driver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       carry_in,
    output bcd_digit_t value,
    output logic       carry_out
);
    assign carry_out = carry_in && (value == BCD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (carry_in)
            value <= carry_out ? '0 : value + 4'd1;
    end
endmodule

// File: rtl/bcd_scan_driver.sv
// 4-decade BCD event counter with hold snapshot and a multiplexed, anti-ghost
// blanked scan of a common-cathode display through a BCD-to-7-segment decoder.
module bcd_scan_driver
    import bcd_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    bcd_scan_driver_if.slave   bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_P  = PW'(BLANK_CYC);

    bcd_word_t             count;
    bcd_word_t             snap;
    logic [NUM_DIGITS:0]   carry;
    logic [PW-1:0]         presc;
    digit_idx_t            idx;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  blank_win;
    logic                  zero_blank;

    bcd_digit_t            bcd_q;
    logic                  bi_n_q;
    logic                  lt_n_q;
    logic [NUM_DIGITS-1:0] sel_q;
    logic                  ovf_q;

    // clr kills the carry chain at its root, so clr never produces ovf
    assign carry[0] = bus.inc & ~bus.clr;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
        bcd_decade u_dec (
            .clk       (clk),
            .rst       (rst),
            .clear     (bus.clr),
            .carry_in  (carry[k]),
            .value     (count[k]),
            .carry_out (carry[k+1])
        );
    end

    // upper_zero[k]: decade k and every decade above it are zero in the snapshot
    always_comb begin
        upper_zero = '0;
        upper_zero[NUM_DIGITS-1] = (snap[NUM_DIGITS-1] == '0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--)
            upper_zero[k] = upper_zero[k+1] && (snap[k] == '0);
    end

    assign blank_win  = (presc < BLANK_P);
    assign zero_blank = (idx != '0) && upper_zero[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap   <= '0;
            presc  <= '0;
            idx    <= '0;
            bcd_q  <= '0;
            bi_n_q <= 1'b0;
            lt_n_q <= 1'b1;
            sel_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q  <= carry[NUM_DIGITS];
            lt_n_q <= ~bus.lamp_test;
            if (!bus.hold)
                snap <= count;
            if (presc == PRESC_TC) begin
                presc <= '0;
                idx   <= idx + 1'b1;
            end else begin
                presc <= presc + PW'(1);
            end
            // bcd keeps its last value through the blank window
            if (blank_win) begin
                sel_q  <= '0;
                bi_n_q <= 1'b0;
            end else begin
                sel_q  <= digit_onehot(idx);
                bcd_q  <= snap[idx];
                bi_n_q <= bus.lamp_test | ~zero_blank;
            end
        end
    end

    assign bus.bcd       = bcd_q;
    assign bus.bi_n      = bi_n_q;
    assign bus.lt_n      = lt_n_q;
    assign bus.digit_sel = sel_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver: decimal reference model compared every cycle plus literal scenario checks.
module tb_bcd_scan_driver;
    import bcd_scan_driver_pkg::*;

    localparam int SD = 4;
    localparam int BC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    bcd_scan_driver_if bus ();

    bcd_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: count and snapshot as plain decimal integers, digits by division
    int m_cnt = 0, m_snap = 0, m_presc = 0, m_idx = 0;
    int pow10 [4] = '{1, 10, 100, 1000};
    logic [3:0] e_bcd = '0, e_sel = '0;
    logic e_bi = 1'b0, e_lt = 1'b1, e_ovf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_snap = 0; m_presc = 0; m_idx = 0;
            e_bcd = '0; e_sel = '0; e_bi = 1'b0; e_lt = 1'b1; e_ovf = 1'b0;
        end else begin
            if (m_presc < BC) begin
                e_sel = '0;
                e_bi  = 1'b0;
            end else begin
                e_sel = 4'(1 << m_idx);
                e_bcd = 4'((m_snap / pow10[m_idx]) % 10);
                e_bi  = bus.lamp_test || !(m_idx >= 1 && m_snap < pow10[m_idx]);
            end
            e_lt  = !bus.lamp_test;
            e_ovf = bus.inc && !bus.clr && (m_cnt == 9999);
            if (!bus.hold) m_snap = m_cnt;
            if (bus.clr) m_cnt = 0;
            else if (bus.inc) m_cnt = (m_cnt + 1) % 10000;
            if (m_presc == SD - 1) begin
                m_presc = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_presc++;
            end
        end
        #1;
        check("model_bcd", 32'(bus.bcd), 32'(e_bcd));
        check("model_sel", 32'(bus.digit_sel), 32'(e_sel));
        check("model_bi_n", 32'(bus.bi_n), 32'(e_bi));
        check("model_lt_n", 32'(bus.lt_n), 32'(e_lt));
        check("model_ovf", 32'(bus.ovf), 32'(e_ovf));
    end

    task automatic inc_n(input int n);
        bus.inc = 1'b1;
        repeat (n) @(negedge clk);
        bus.inc = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_pulse();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    task automatic expect_slot(input string name, input logic [3:0] sel,
                               input logic [3:0] b, input logic bi);
        int n = 0;
        while (bus.digit_sel !== sel && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_sel"}, 32'(bus.digit_sel), 32'(sel));
        check({name, "_bcd"}, 32'(bus.bcd), 32'(b));
        check({name, "_bi_n"}, 32'(bus.bi_n), 32'(bi));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inc = 1'b0; bus.clr = 1'b0; bus.hold = 1'b0; bus.lamp_test = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(bus.bcd), 32'd0);
        check("rst_bi_n", 32'(bus.bi_n), 32'd0);
        check("rst_lt_n", 32'(bus.lt_n), 32'd1);
        check("rst_sel", 32'(bus.digit_sel), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_blank_sel", 32'(bus.digit_sel), 32'd0);
        @(negedge clk);
        check("rel_first_sel", 32'(bus.digit_sel), 32'd1);
        check("rel_first_bcd", 32'(bus.bcd), 32'd0);

        // 0305 scan pattern with the thousands decade leading-zero blanked
        inc_n(305);
        expect_slot("s305_u", 4'b0001, 4'd5, 1'b1);
        expect_slot("s305_t", 4'b0010, 4'd0, 1'b1);
        expect_slot("s305_h", 4'b0100, 4'd3, 1'b1);
        expect_slot("s305_k", 4'b1000, 4'd0, 1'b0);

        // async reset mid-count at 0457 while incrementing
        clear_pulse();
        inc_n(457);
        expect_slot("s457_t", 4'b0010, 4'd5, 1'b1);
        bus.inc = 1'b1;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_bcd", 32'(bus.bcd), 32'd0);
        check("arst_bi_n", 32'(bus.bi_n), 32'd0);
        check("arst_lt_n", 32'(bus.lt_n), 32'd1);
        check("arst_sel", 32'(bus.digit_sel), 32'd0);
        check("arst_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        bus.inc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arel_blank_sel", 32'(bus.digit_sel), 32'd0);
        expect_slot("arel_u", 4'b0001, 4'd0, 1'b1);
        expect_slot("arel_t", 4'b0010, 4'd0, 1'b0);

        // 9998 -> 9999 -> 0000 with a single-cycle ovf
        clear_pulse();
        inc_n(9998);
        bus.inc = 1'b1;
        @(negedge clk);
        check("wrap_9999_ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        bus.inc = 1'b0;
        check("wrap_ovf_hi", 32'(bus.ovf), 32'd1);
        @(negedge clk);
        check("wrap_ovf_lo", 32'(bus.ovf), 32'd0);
        repeat (3) @(negedge clk);
        expect_slot("wrap_u", 4'b0001, 4'd0, 1'b1);
        expect_slot("wrap_k", 4'b1000, 4'd0, 1'b0);

        // inc and clr together at 0042
        clear_pulse();
        inc_n(42);
        expect_slot("s42_t", 4'b0010, 4'd4, 1'b1);
        bus.inc = 1'b1; bus.clr = 1'b1;
        @(negedge clk);
        bus.inc = 1'b0; bus.clr = 1'b0;
        check("incclr_ovf", 32'(bus.ovf), 32'd0);
        repeat (3) @(negedge clk);
        expect_slot("incclr_u", 4'b0001, 4'd0, 1'b1);
        expect_slot("incclr_t", 4'b0010, 4'd0, 1'b0);

        // hold freezes the display while counting continues
        clear_pulse();
        inc_n(12);
        bus.hold = 1'b1;
        inc_n(5);
        expect_slot("hold_u", 4'b0001, 4'd2, 1'b1);
        expect_slot("hold_t", 4'b0010, 4'd1, 1'b1);
        bus.hold = 1'b0;
        repeat (3) @(negedge clk);
        expect_slot("unhold_u", 4'b0001, 4'd7, 1'b1);
        expect_slot("unhold_t", 4'b0010, 4'd1, 1'b1);

        // lamp test at 0000 overrides zero blanking
        clear_pulse();
        repeat (3) @(negedge clk);
        bus.lamp_test = 1'b1;
        repeat (2) @(negedge clk);
        check("lt_lt_n", 32'(bus.lt_n), 32'd0);
        expect_slot("lt_u", 4'b0001, 4'd0, 1'b1);
        expect_slot("lt_t", 4'b0010, 4'd0, 1'b1);
        expect_slot("lt_h", 4'b0100, 4'd0, 1'b1);
        expect_slot("lt_k", 4'b1000, 4'd0, 1'b1);
        bus.lamp_test = 1'b0;
        repeat (2) @(negedge clk);
        check("lt_off_lt_n", 32'(bus.lt_n), 32'd1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
